// File: rtl/div_seq_16.sv
// 16-bit unsigned restoring divider: one quotient bit per clock, 17-cycle latency (1 for divide-by-zero).
// A start is accepted only in IDLE or DONE. A start during CALC is dropped, not queued. The caller must latch results on done.

module full_sub_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        bin,
  output logic [15:0] diff,
  output logic        borrow
);

  logic [16:0] bchain;

  assign bchain[0] = bin;

  for (genvar i = 0; i < 16; i++) begin : g_bit
    assign diff[i]       = a[i] ^ b[i] ^ bchain[i];
    assign bchain[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bchain[i]);
  end

  assign borrow = bchain[16];

endmodule

module div_seq_16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] r_q;
  logic [15:0] q_q;
  logic [15:0] d_q;
  logic [4:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] quot_q;
  logic [15:0] rem_q;
  logic        dbz_q;

  logic [15:0] s_d;
  logic        carry_d;
  logic [15:0] sub_diff;
  logic        sub_borrow;
  logic        qbit_d;
  logic [15:0] r_d;
  logic [15:0] q_d;

  // Trial subtraction of the divisor from the shifted partial remainder.
  assign s_d     = {r_q[14:0], q_q[15]};
  assign carry_d = r_q[15];

  full_sub_16 u_sub (
    .a      (s_d),
    .b      (d_q),
    .bin    (1'b0),
    .diff   (sub_diff),
    .borrow (sub_borrow)
  );

  // A set carry means the 17-bit shifted value already exceeds D, so the
  // wrapped 16-bit difference is exact.
  assign qbit_d = carry_d | ~sub_borrow;
  assign r_d    = qbit_d ? sub_diff : s_d;
  assign q_d    = {q_q[14:0], qbit_d};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= 16'h0000;
      q_q     <= 16'h0000;
      d_q     <= 16'h0000;
      cnt_q   <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= 16'h0000;
      rem_q   <= 16'h0000;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            if (divisor == 16'h0000) begin
              state_q <= DONE;
              quot_q  <= 16'hFFFF;
              rem_q   <= dividend;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= CALC;
              q_q     <= dividend;
              r_q     <= 16'h0000;
              d_q     <= divisor;
              cnt_q   <= 5'd0;
              dbz_q   <= 1'b0;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        CALC: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd15) begin
            state_q <= DONE;
            quot_q  <= q_d;
            rem_q   <= r_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/div_seq_16.md
# div_seq_16

Sequential 16-bit unsigned restoring divider for the CPU datapath ALU. It takes a dividend and divisor on a start pulse and iterates one quotient bit per clock. Each iteration's trial subtraction is done by an instance of the team's 16-bit borrow-ripple subtractor `full_sub_16` (borrow-in tied to 0), and the block consumes that instance's `diff`/`borrow` outputs. The quotient and remainder are returned with a one-cycle done pulse to the ALU result mux.

## Interface
Parameters: none; the width is fixed at 16 to match `full_sub_16`.

Ports:
- `clk` — input, 1 — the single clock; all state updates on its rising edge.
- `rst` — input, 1 — reset; one clock, synchronous and active-high.
- `start` — input, 1 — request a division; sampled only when the block can accept.
- `dividend` — input, 16 — unsigned dividend; sampled on the accepting edge.
- `divisor` — input, 16 — unsigned divisor; sampled on the accepting edge.
- `busy` — output, 1 — high while iterating (CALC state).
- `done` — output, 1 — one-cycle pulse; results are valid from this cycle onward.
- `quotient` — output, 16 — result quotient; held until the next accepted start.
- `remainder` — output, 16 — result remainder; held until the next accepted start.
- `div_by_zero` — output, 1 — set with `done` when the captured divisor was 0; held with the results.

## Operation
- States: IDLE, CALC, DONE. Registers: R[15:0] (partial remainder), Q[15:0] (dividend shifting into quotient), D[15:0] (divisor), cnt[4:0].
- Reset (any state, including mid-CALC):
  - state goes to IDLE; R, Q, D and cnt clear to 0.
  - `busy`, `done`, `div_by_zero` go to 0; `quotient` and `remainder` go to 16'h0000.
  - An operation in flight is aborted; no `done` is produced for it.
- Start acceptance: `start=1` in IDLE or DONE is accepted. `start` while in CALC is ignored, with no queuing.
- On an accepted start with divisor != 0:
  - Q<=dividend, R<=0, D<=divisor, cnt<=0, state<=CALC.
  - `div_by_zero`<=0.
- On an accepted start with divisor == 0:
  - state<=DONE; no CALC cycles are run.
  - `quotient`<=16'hFFFF, `remainder`<=dividend, `div_by_zero`<=1.
- Each CALC cycle (one iteration):
  - S = {R[14:0], Q[15]}, with carry-out c = R[15].
  - `full_sub_16` computes S − D with bin=0, giving diff and borrow.
  - If c==1 or borrow==0: R<=diff and the new quotient bit is 1. Otherwise R<=S and the new quotient bit is 0.
  - Q<={Q[14:0], qbit}; cnt<=cnt+1.
  - When c==1 the 17-bit value exceeds D, so the wrapped 16-bit diff is the exact remainder; no 17th subtractor bit is needed.
- After the 16th CALC cycle (cnt==15 at that edge): `quotient`<=final Q, `remainder`<=final R, state<=DONE.
- DONE lasts one cycle unless a start is accepted in it, in which case the block goes straight to CALC (or to DONE again if the new divisor is 0). Otherwise state returns to IDLE.
- Outputs hold their last values in IDLE and through the following CALC until the next results are written. The ALU must latch on `done`.

## Timing
- Let E0 be the edge that accepts `start` with a nonzero divisor.
- CALC occupies the cycles after edges E0 through E15; `busy`=1 exactly in those 16 cycles.
- Results are written at E16; `done`=1 for the one cycle after E16, i.e. 17 cycles after E0.
- `busy`=0 in the DONE cycle.
- Divide by zero: `done`=1 in the cycle after E0 (latency 1); `busy` stays 0.
- Maximum throughput: a start accepted in the DONE cycle gives back-to-back operations every 17 cycles.
- `rst` wins over `start` on the same edge.
- The subtractor path is combinational within one cycle: a 16-stage borrow ripple plus the R mux must meet the clock period.

## Test plan
- 100 / 7: `start` at E0 -> `busy` high for 16 cycles, `done` pulse 17 cycles after E0, `quotient`=14, `remainder`=2, `div_by_zero`=0.
- 16'hFFFF / 16'h8001 (carry-out path) -> `quotient`=1, `remainder`=16'h7FFE. Then 16'hFFFF / 1 -> `quotient`=16'hFFFF, `remainder`=0.
- 5 / 0 -> `done` in the cycle after E0, `busy` never high, `quotient`=16'hFFFF, `remainder`=5, `div_by_zero`=1. A following 9 / 3 clears `div_by_zero` to 0 and gives `quotient`=3, `remainder`=0.
- 3 / 10 -> `quotient`=0, `remainder`=3. Re-assert `start` with 50 / 5 during CALC cycle 8 -> ignored; the first result is unchanged. Assert `start` with 50 / 5 in the DONE cycle -> accepted; next `done` gives `quotient`=10, `remainder`=0.
- `rst` for one cycle at CALC cycle 10 of 1000 / 3 -> all outputs 0 on the next cycle, no `done` produced. A subsequent 1000 / 3 returns `quotient`=333, `remainder`=1.
- 2000 random nonzero and zero-divisor pairs against a behavioural `/` and `%` reference model -> exact match on every `done`. `done` must be exactly one cycle wide every time.
